map_probe_scheduler: RTL and testbench

//  Time-shares one map ROM port between the pixel texture fetch and the ball

---
 rtl/map_sched_pkg.sv | 20 ++
 rtl/map_probe_scheduler_if.sv | 8 +
 rtl/map_addr_calc.sv | 10 +
 rtl/map_probe_scheduler.sv | 118 +++++++++++
 tb/tb_map_probe_scheduler.sv | 335 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/map_sched_pkg.sv
// map_sched_pkg: shared types, raster constants and probe-point clamping helpers
package map_sched_pkg;
    localparam int H_ACTIVE = 800;
    localparam int V_ACTIVE = 600;
    localparam int ADDR_W   = 19;
    typedef enum logic [2:0] {PIXEL, LATCH, ISSUE, DRAIN, DONE} state_t;
    typedef enum logic [1:0] {PRB_L, PRB_R, PRB_U, PRB_D} probe_idx_t;
    typedef struct packed {
        logic       valid;
        logic       is_probe;
        probe_idx_t idx;
    } tag_t;
    // compare before the arithmetic so a coordinate near an edge saturates instead of wrapping
    function automatic logic [9:0] clamp_sub(input logic [9:0] a, input int r);
        return a >= 10'(r) ? a - 10'(r) : '0;
    endfunction
    function automatic logic [9:0] clamp_add(input logic [9:0] a, input int r, input int lim);
        return {1'b0, a} + 11'(r) > 11'(lim - 1) ? 10'(lim - 1) : a + 10'(r);
    endfunction
endpackage

// File: rtl/map_probe_scheduler_if.sv
// map_probe_scheduler_if: map ROM read port, address out and data back
interface map_probe_scheduler_if #(parameter int DATA_W = 1);
    import map_sched_pkg::*;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;
    modport master (output rom_addr, input rom_data);
    modport slave (input rom_addr, output rom_data);
endinterface

// File: rtl/map_addr_calc.sv
// map_addr_calc: linear map address y*H_ACTIVE + x
module map_addr_calc
    import map_sched_pkg::*;
(
    input  logic [9:0]        x,
    input  logic [9:0]        y,
    output logic [ADDR_W-1:0] addr
);
    assign addr = ADDR_W'(y) * ADDR_W'(H_ACTIVE) + ADDR_W'(x);
endmodule

// File: rtl/map_probe_scheduler.sv
// map_probe_scheduler: shares one map ROM port between raster texture fetch
// and the four-point ball collision probe run during vertical blanking
module map_probe_scheduler
    import map_sched_pkg::*;
#(
    parameter int BALL_R  = 10,
    parameter int ROM_LAT = 1,
    parameter int DATA_W  = 1
) (
    input  logic                  pixel_clk,
    input  logic                  rst_n,
    input  logic [9:0]            h_coord,
    input  logic [9:0]            v_coord,
    input  logic                  end_of_frame,
    input  logic [9:0]            ball_x,
    input  logic [9:0]            ball_y,
    map_probe_scheduler_if.master rom,
    output logic [DATA_W-1:0]     tex_data,
    output logic                  tex_valid,
    output logic                  coll_l,
    output logic                  coll_r,
    output logic                  coll_u,
    output logic                  coll_d,
    output logic                  probe_done,
    output logic                  busy,
    output logic                  overrun
);
    state_t            state, nxt;
    logic [1:0]        cnt;
    logic [9:0]        bx_q, by_q, bx, by, px, py;
    logic [ADDR_W-1:0] addr;
    logic              active, abort, probe_issue, pix_hit;
    probe_idx_t        sel;
    tag_t              tag_q, tag_d;
    tag_t              pipe [ROM_LAT];
    logic [3:0]        hits, hits_nxt;

    assign active = h_coord < 10'(H_ACTIVE) && v_coord < 10'(V_ACTIVE);
    assign abort  = busy && active;

    always_ff @(posedge pixel_clk) begin
        if (!rst_n) begin
            state <= PIXEL;
            cnt   <= '0;
        end else begin
            state <= nxt;
            cnt   <= nxt != state ? '0 : cnt + 2'd1;
        end
    end

    always_comb begin
        nxt = state;
        case (state)
            PIXEL:   nxt = end_of_frame ? LATCH : PIXEL;
            LATCH:   nxt = ISSUE;
            ISSUE:   nxt = cnt == 2'd3 ? DRAIN : ISSUE;
            DRAIN:   nxt = cnt == 2'(ROM_LAT - 1) ? DONE : DRAIN;
            default: nxt = PIXEL;
        endcase
        nxt = abort ? PIXEL : nxt;
    end

    always_comb begin
        busy       = state == LATCH || state == ISSUE || state == DRAIN;
        probe_done = state == DONE;
    end

    // rom_addr is registered, so LATCH already loads the left point from the live ball inputs
    assign bx          = state == LATCH ? ball_x : bx_q;
    assign by          = state == LATCH ? ball_y : by_q;
    assign sel         = state == LATCH ? PRB_L : probe_idx_t'(cnt + 2'd1);
    assign probe_issue = nxt == ISSUE;
    assign px = sel == PRB_L ? clamp_sub(bx, BALL_R) : sel == PRB_R ? clamp_add(bx, BALL_R, H_ACTIVE) : bx;
    assign py = sel == PRB_U ? clamp_sub(by, BALL_R) : sel == PRB_D ? clamp_add(by, BALL_R, V_ACTIVE) : by;

    map_addr_calc u_addr (
        .x    (probe_issue ? px : h_coord),
        .y    (probe_issue ? py : v_coord),
        .addr (addr)
    );

    assign tag_d   = pipe[ROM_LAT-1];
    assign pix_hit = nxt == PIXEL && tag_d.valid && !tag_d.is_probe;

    always_comb begin
        hits_nxt = hits;
        if (tag_d.valid && tag_d.is_probe) hits_nxt[tag_d.idx] = |rom.rom_data;
    end

    always_ff @(posedge pixel_clk) begin
        if (!rst_n) begin
            rom.rom_addr <= '0;
            tag_q        <= '0;
            for (int i = 0; i < ROM_LAT; i++) pipe[i] <= '0;
            bx_q         <= '0;
            by_q         <= '0;
            hits         <= '0;
            {coll_d, coll_u, coll_r, coll_l} <= '0;
            tex_valid    <= 1'b0;
            tex_data     <= '0;
            overrun      <= 1'b0;
        end else begin
            rom.rom_addr <= addr;
            tag_q        <= {probe_issue || active, probe_issue, sel};
            pipe[0]      <= tag_q;
            for (int i = 1; i < ROM_LAT; i++) pipe[i] <= pipe[i-1];
            if (state == LATCH) begin
                bx_q <= ball_x;
                by_q <= ball_y;
            end
            hits         <= hits_nxt;
            if (nxt == DONE) {coll_d, coll_u, coll_r, coll_l} <= hits_nxt;
            tex_valid    <= pix_hit;
            tex_data     <= pix_hit ? rom.rom_data : '0;
            overrun      <= overrun || abort || (end_of_frame && state != PIXEL);
        end
    end
endmodule

// File: tb/tb_map_probe_scheduler.sv
// tb_map_probe_scheduler: drives ROM_LAT=1 and ROM_LAT=3 instances with shared stimulus
// and checks both against a coordinate-level model of the probe and raster rules
module tb_map_probe_scheduler;
    import map_sched_pkg::*;
    localparam int LAT0 = 1;
    localparam int LAT1 = 3;
    localparam int BR   = 10;

    logic              pixel_clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [9:0]        h_coord = 10'd0, v_coord = 10'd620, ball_x = 10'd0, ball_y = 10'd0;
    logic              end_of_frame = 1'b0;
    logic [1:0]        tex_d, tex_v, c_l, c_r, c_u, c_d, done, busy, ovr;
    logic [ADDR_W-1:0] raddr [2];
    bit                rom_set [int];
    logic              q0 = 1'b0;
    logic [2:0]        q1 = 3'b0;
    logic [3:0]        exp_coll [2];
    int                checks = 0;
    int                errors = 0;

    map_probe_scheduler_if #(.DATA_W(1)) rif0 ();
    map_probe_scheduler_if #(.DATA_W(1)) rif1 ();

    map_probe_scheduler #(.BALL_R(BR), .ROM_LAT(LAT0), .DATA_W(1)) u_lat1 (
        .pixel_clk(pixel_clk), .rst_n(rst_n), .h_coord(h_coord), .v_coord(v_coord),
        .end_of_frame(end_of_frame), .ball_x(ball_x), .ball_y(ball_y), .rom(rif0),
        .tex_data(tex_d[0]), .tex_valid(tex_v[0]), .coll_l(c_l[0]), .coll_r(c_r[0]),
        .coll_u(c_u[0]), .coll_d(c_d[0]), .probe_done(done[0]), .busy(busy[0]), .overrun(ovr[0]));

    map_probe_scheduler #(.BALL_R(BR), .ROM_LAT(LAT1), .DATA_W(1)) u_lat3 (
        .pixel_clk(pixel_clk), .rst_n(rst_n), .h_coord(h_coord), .v_coord(v_coord),
        .end_of_frame(end_of_frame), .ball_x(ball_x), .ball_y(ball_y), .rom(rif1),
        .tex_data(tex_d[1]), .tex_valid(tex_v[1]), .coll_l(c_l[1]), .coll_r(c_r[1]),
        .coll_u(c_u[1]), .coll_d(c_d[1]), .probe_done(done[1]), .busy(busy[1]), .overrun(ovr[1]));

    always #5 pixel_clk = ~pixel_clk;

    // ROM model: a sparse set of '1' addresses, delayed by each instance's latency
    always @(posedge pixel_clk) begin
        q0 <= rom_set.exists(int'(rif0.rom_addr)) != 0;
        q1 <= {q1[1:0], rom_set.exists(int'(rif1.rom_addr)) != 0};
    end
    assign rif0.rom_data = q0;
    assign rif1.rom_data = q1[2];
    assign raddr[0] = rif0.rom_addr;
    assign raddr[1] = rif1.rom_addr;

    function automatic int lat(int i);
        return i == 0 ? LAT0 : LAT1;
    endfunction

    function automatic int probe_addr(int x, int y, int k);
        int px = x;
        int py = y;
        if (k == 0) px = x - BR < 0 ? 0 : x - BR;
        if (k == 1) px = x + BR > H_ACTIVE - 1 ? H_ACTIVE - 1 : x + BR;
        if (k == 2) py = y - BR < 0 ? 0 : y - BR;
        if (k == 3) py = y + BR > V_ACTIVE - 1 ? V_ACTIVE - 1 : y + BR;
        return py * H_ACTIVE + px;
    endfunction

    function automatic logic [3:0] exp_hits(int x, int y);
        logic [3:0] e;
        for (int k = 0; k < 4; k++) e[k] = rom_set.exists(probe_addr(x, y, k)) != 0;
        return e;
    endfunction

    function automatic logic [3:0] coll_of(int i);
        return {c_d[i], c_u[i], c_r[i], c_l[i]};
    endfunction

    task automatic tick();
        @(posedge pixel_clk);
        #1;
    endtask

    task automatic idle();
        h_coord = 10'd0;
        v_coord = 10'd620;
    endtask

    task automatic test_reset();
        idle();
        ball_x = 10'd100;
        ball_y = 10'd100;
        rst_n = 1'b0;
        repeat (3) tick();
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({tex_v[i], tex_d[i], coll_of(i), done[i], busy[i], ovr[i]} !== 9'b0) begin
                errors++;
                $display("FAIL reset_outputs lat=%0d got %b want 0", lat(i),
                         {tex_v[i], tex_d[i], coll_of(i), done[i], busy[i], ovr[i]});
            end
            checks++;
            if (raddr[i] !== '0) begin
                errors++;
                $display("FAIL reset_rom_addr lat=%0d got %0d want 0", lat(i), raddr[i]);
            end
        end
        rst_n = 1'b1;
        tick();
        rom_set.delete();
        rom_set[probe_addr(100, 100, 1)] = 1'b1;
        end_of_frame = 1'b1;
        tick();
        end_of_frame = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (done[i] !== 1'b0 || busy[i] !== 1'b0 || ovr[i] !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_abort lat=%0d c=%0d got done=%b busy=%b ovr=%b want 000",
                             lat(i), c, done[i], busy[i], ovr[i]);
                end
            end
            tick();
        end
        end_of_frame = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            tick();
            end_of_frame = 1'b0;
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (done[i] !== (c == 6 + lat(i))) begin
                    errors++;
                    $display("FAIL post_reset_done lat=%0d c=%0d got %b", lat(i), c, done[i]);
                end
                if (c == 6 + lat(i)) begin
                    exp_coll[i] = 4'b0010;
                    checks++;
                    if (coll_of(i) !== exp_coll[i]) begin
                        errors++;
                        $display("FAIL post_reset_coll lat=%0d got %b want %b", lat(i), coll_of(i), exp_coll[i]);
                    end
                end
            end
        end
    endtask

    task automatic test_probe_points();
        int bxs[8];
        int bys[8];
        int fx[4] = '{476000, 476015, 468005, 479205};
        int ea;
        bxs[0] = 200; bys[0] = 300;
        bxs[1] = 5;   bys[1] = 595;
        bxs[2] = 795; bys[2] = 3;
        for (int n = 3; n < 8; n++) begin
            bxs[n] = $urandom_range(0, 799);
            bys[n] = $urandom_range(0, 599);
        end
        for (int n = 0; n < 8; n++) begin
            rom_set.delete();
            if (n == 0) rom_set[300 * H_ACTIVE + 210] = 1'b1;
            else if (n == 1) begin
                rom_set[476000] = 1'b1;
                rom_set[479205] = 1'b1;
            end else
                for (int k = 0; k < 4; k++) if ($urandom_range(0, 1) == 1) rom_set[probe_addr(bxs[n], bys[n], k)] = 1'b1;
            ball_x = 10'(bxs[n]);
            ball_y = 10'(bys[n]);
            end_of_frame = 1'b1;
            for (int c = 1; c <= 12; c++) begin
                tick();
                end_of_frame = 1'b0;
                if (c == 2) begin
                    ball_x = 10'($urandom);
                    ball_y = 10'($urandom);
                end
                for (int i = 0; i < 2; i++) begin
                    if (c >= 2 && c <= 5) begin
                        ea = n == 1 ? fx[c-2] : probe_addr(bxs[n], bys[n], c - 2);
                        checks++;
                        if (raddr[i] !== ADDR_W'(ea)) begin
                            errors++;
                            $display("FAIL probe_addr lat=%0d ball=(%0d,%0d) c=%0d got %0d want %0d",
                                     lat(i), bxs[n], bys[n], c, raddr[i], ea);
                        end
                    end
                    checks++;
                    if (busy[i] !== (c <= 5 + lat(i)) || done[i] !== (c == 6 + lat(i))) begin
                        errors++;
                        $display("FAIL probe_timing lat=%0d c=%0d got busy=%b done=%b", lat(i), c, busy[i], done[i]);
                    end
                    if (c == 6 + lat(i)) begin
                        exp_coll[i] = n == 0 ? 4'b0010 : exp_hits(bxs[n], bys[n]);
                        checks++;
                        if (coll_of(i) !== exp_coll[i]) begin
                            errors++;
                            $display("FAIL probe_coll lat=%0d ball=(%0d,%0d) got %b want %b",
                                     lat(i), bxs[n], bys[n], coll_of(i), exp_coll[i]);
                        end
                    end
                end
            end
        end
    endtask

    task automatic test_pixel();
        int hs[40];
        int vs[40];
        int j;
        logic ev, ed;
        rom_set.delete();
        for (int n = 0; n < 40; n++) begin
            hs[n] = $urandom_range(0, 900);
            vs[n] = $urandom_range(0, 700);
            if ($urandom_range(0, 1) == 1) rom_set[vs[n] * H_ACTIVE + hs[n]] = 1'b1;
        end
        hs[5] = 10;  vs[5] = 20;
        hs[6] = 800; vs[6] = 20;
        rom_set[20 * H_ACTIVE + 10] = 1'b1;
        rom_set[20 * H_ACTIVE + 800] = 1'b1;
        for (int c = 0; c < 46; c++) begin
            if (c < 40) begin
                h_coord = 10'(hs[c]);
                v_coord = 10'(vs[c]);
            end else idle();
            tick();
            for (int i = 0; i < 2; i++) begin
                j = c + 1 - 2 - lat(i);
                if (j >= 0 && j < 40) begin
                    ev = hs[j] < H_ACTIVE && vs[j] < V_ACTIVE;
                    ed = rom_set.exists(vs[j] * H_ACTIVE + hs[j]) != 0;
                    checks++;
                    if (tex_v[i] !== ev || (ev && tex_d[i] !== ed)) begin
                        errors++;
                        $display("FAIL pixel_tex lat=%0d pix=(%0d,%0d) got v=%b d=%b want v=%b d=%b",
                                 lat(i), hs[j], vs[j], tex_v[i], tex_d[i], ev, ed);
                    end
                end
            end
        end
    endtask

    task automatic test_overrun();
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (ovr[i] !== 1'b0) begin
                errors++;
                $display("FAIL overrun_idle lat=%0d got %b want 0", lat(i), ovr[i]);
            end
        end
        rom_set.delete();
        rom_set[probe_addr(400, 300, 2)] = 1'b1;
        ball_x = 10'd400;
        ball_y = 10'd300;
        end_of_frame = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            tick();
            end_of_frame = c == 3;
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (ovr[i] !== (c >= 4) || done[i] !== (c == 6 + lat(i))) begin
                    errors++;
                    $display("FAIL eof_repulse lat=%0d c=%0d got ovr=%b done=%b", lat(i), c, ovr[i], done[i]);
                end
                if (c == 6 + lat(i)) begin
                    exp_coll[i] = 4'b0100;
                    checks++;
                    if (coll_of(i) !== exp_coll[i]) begin
                        errors++;
                        $display("FAIL eof_repulse_coll lat=%0d got %b want %b", lat(i), coll_of(i), exp_coll[i]);
                    end
                end
            end
        end
    endtask

    task automatic test_abort();
        idle();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        rom_set.delete();
        rom_set[probe_addr(300, 200, 0)] = 1'b1;
        rom_set[probe_addr(300, 200, 2)] = 1'b1;
        ball_x = 10'd300;
        ball_y = 10'd200;
        end_of_frame = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            tick();
            end_of_frame = 1'b0;
            for (int i = 0; i < 2; i++)
                if (c == 6 + lat(i)) begin
                    exp_coll[i] = 4'b0101;
                    checks++;
                    if (coll_of(i) !== exp_coll[i] || done[i] !== 1'b1) begin
                        errors++;
                        $display("FAIL abort_setup lat=%0d got coll=%b done=%b want %b/1",
                                 lat(i), coll_of(i), done[i], exp_coll[i]);
                    end
                end
        end
        rom_set.delete();
        rom_set[probe_addr(300, 200, 1)] = 1'b1;
        rom_set[probe_addr(300, 200, 3)] = 1'b1;
        end_of_frame = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            tick();
            end_of_frame = 1'b0;
            if (c == 4) begin
                h_coord = 10'd0;
                v_coord = 10'd0;
            end
            if (c == 7) idle();
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (done[i] !== 1'b0 || ovr[i] !== (c >= 5) || busy[i] !== (c <= 4) || coll_of(i) !== exp_coll[i]) begin
                    errors++;
                    $display("FAIL raster_abort lat=%0d c=%0d got done=%b ovr=%b busy=%b coll=%b want coll=%b",
                             lat(i), c, done[i], ovr[i], busy[i], coll_of(i), exp_coll[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_probe_points();
        test_pixel();
        test_overrun();
        test_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
